mux_sel_sequencer: RTL and testbench

Sequencing controller for the two-way AND/bypass select mux: owns the mux `sel` line and arbitrates between two requesters, one needing the `dataA & dataB` path (`sel=1`) and one needing the `a0` path (`sel=0`). The controller only changes `sel` between ownership periods and blanks the mux output for a programmable settle window after every `sel` change, so no consumer samples `mux_out` while a select-induced glitch can still propagate. It sits directly beside the mux and drives its `sel` input.

---
 rtl/mux_sel_sequencer.sv | 148 ++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for the AND/bypass mux: arbitrates two requesters, changes sel only between
// ownership periods and blanks out_valid for SETTLE_CYCLES after every sel change or reset.
// Optional macro MUX_SEL_SEQ_PREEMPT_EN: owner is preempted after HOLD_MAX grant cycles.
module mux_sel_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_MAX      = 8,
  parameter int CW            = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_and,
  input  logic req_a0,
  output logic sel,
  output logic gnt_and,
  output logic gnt_a0,
  output logic out_valid,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GRANT  = 2'd2
  } state_t;

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_MAX);

  state_t        r_state;
  state_t        w_nxt_state;
  logic          r_sel;
  logic          w_nxt_sel;
  logic          r_tgt_vld;
  logic          w_nxt_tgt_vld;
  logic [CW-1:0] r_settle_cnt;
  logic [CW-1:0] w_nxt_settle_cnt;
  logic [CW-1:0] r_hold_cnt;
  logic [CW-1:0] w_nxt_hold_cnt;
  logic          r_gnt_and;
  logic          r_gnt_a0;
  logic          r_out_valid;
  logic          r_busy;

  // Requests seen relative to the current select: "cur" matches sel, "oth" needs a switch.
  // While settling the target always matches sel, so target's request is w_req_cur.
  logic w_req_cur;
  logic w_req_oth;
  logic w_preempt;

  assign w_req_cur = r_sel ? req_and : req_a0;
  assign w_req_oth = r_sel ? req_a0  : req_and;

`ifdef MUX_SEL_SEQ_PREEMPT_EN
  assign w_preempt = (r_hold_cnt >= HOLD_LD) && w_req_oth;
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_sel        = r_sel;
    w_nxt_tgt_vld    = r_tgt_vld;
    w_nxt_settle_cnt = r_settle_cnt;
    w_nxt_hold_cnt   = r_hold_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_cur) begin
          w_nxt_state    = ST_GRANT;
          w_nxt_hold_cnt = CW'(1);
        end else if (w_req_oth) begin
          w_nxt_state      = ST_SETTLE;
          w_nxt_sel        = ~r_sel;
          w_nxt_tgt_vld    = 1'b1;
          w_nxt_settle_cnt = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt > CW'(1)) begin
          w_nxt_settle_cnt = r_settle_cnt - CW'(1);
        end else if (r_tgt_vld && w_req_cur) begin
          w_nxt_state    = ST_GRANT;
          w_nxt_tgt_vld  = 1'b0;
          w_nxt_hold_cnt = CW'(1);
        end else if (w_req_oth) begin
          w_nxt_sel        = ~r_sel;
          w_nxt_tgt_vld    = 1'b1;
          w_nxt_settle_cnt = SETTLE_LD;
        end else if (w_req_cur) begin
          w_nxt_state    = ST_GRANT;
          w_nxt_tgt_vld  = 1'b0;
          w_nxt_hold_cnt = CW'(1);
        end else begin
          w_nxt_state   = ST_IDLE;
          w_nxt_tgt_vld = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!w_req_cur || w_preempt) begin
          if (w_req_oth) begin
            w_nxt_state      = ST_SETTLE;
            w_nxt_sel        = ~r_sel;
            w_nxt_tgt_vld    = 1'b1;
            w_nxt_settle_cnt = SETTLE_LD;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          w_nxt_hold_cnt = (r_hold_cnt >= HOLD_LD) ? HOLD_LD : r_hold_cnt + CW'(1);
        end
      end
      default: begin
        w_nxt_state = ST_SETTLE;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_SETTLE;
      r_sel        <= 1'b0;
      r_tgt_vld    <= 1'b0;
      r_settle_cnt <= SETTLE_LD;
      r_hold_cnt   <= '0;
      r_gnt_and    <= 1'b0;
      r_gnt_a0     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_nxt_state;
      r_sel        <= w_nxt_sel;
      r_tgt_vld    <= w_nxt_tgt_vld;
      r_settle_cnt <= w_nxt_settle_cnt;
      r_hold_cnt   <= w_nxt_hold_cnt;
      r_gnt_and    <= (w_nxt_state == ST_GRANT) &&  w_nxt_sel;
      r_gnt_a0     <= (w_nxt_state == ST_GRANT) && !w_nxt_sel;
      r_out_valid  <= (w_nxt_state != ST_SETTLE);
      r_busy       <= (w_nxt_state != ST_IDLE);
    end
  end

  assign sel       = r_sel;
  assign gnt_and   = r_gnt_and;
  assign gnt_a0    = r_gnt_a0;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized bench for mux_sel_sequencer against an ownership/blanking-window reference model.
module tb_mux_sel_sequencer;
  localparam int SETTLE_CYCLES = 2;
  localparam int HOLD_MAX      = 8;
  localparam int CW            = 4;
  localparam int NCYC          = 4000;
`ifdef MUX_SEL_SEQ_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_and;
  logic req_a0;
  logic sel;
  logic gnt_and;
  logic gnt_a0;
  logic out_valid;
  logic busy;

  always #5 clk = ~clk;

  mux_sel_sequencer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .HOLD_MAX     (HOLD_MAX),
    .CW           (CW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_and  (req_and),
    .req_a0   (req_a0),
    .sel      (sel),
    .gnt_and  (gnt_and),
    .gnt_a0   (gnt_a0),
    .out_valid(out_valid),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: path 1 = AND, path 0 = a0, -1 = nobody.
  int m_sel;
  int m_owner;
  int m_blank;   // blank cycles still to be shown, 0 when output is settled
  int m_target;
  int m_hold;    // cycles of grant the owner has enjoyed so far

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_chk++;
    if (got === 32'(exp)) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  task automatic m_switch(input int p);
    m_sel    = p;
    m_target = p;
    m_blank  = SETTLE_CYCLES;
    m_owner  = -1;
  endtask

  task automatic m_grant(input int p);
    m_owner  = p;
    m_blank  = 0;
    m_hold   = 1;
    m_target = -1;
  endtask

  task automatic m_reset();
    m_sel    = 0;
    m_owner  = -1;
    m_blank  = SETTLE_CYCLES;
    m_target = -1;
    m_hold   = 0;
  endtask

  task automatic m_step(input bit r, input bit ra0, input bit rand_);
    bit rq [2];
    int oth;
    rq[0] = ra0;
    rq[1] = rand_;
    oth   = 1 - m_sel;
    if (r) begin
      m_reset();
    end else if (m_blank > 1) begin
      m_blank--;
    end else if (m_blank == 1) begin
      if (m_target >= 0 && rq[m_target]) m_grant(m_target);
      else if (rq[oth])                  m_switch(oth);
      else if (rq[m_sel])                m_grant(m_sel);
      else begin
        m_blank  = 0;
        m_owner  = -1;
        m_target = -1;
      end
    end else if (m_owner >= 0) begin
      if (!rq[m_owner] || (PREEMPT && m_hold >= HOLD_MAX && rq[oth])) begin
        if (rq[oth]) m_switch(oth);
        else         m_owner = -1;
      end else begin
        m_hold = (m_hold + 1 > HOLD_MAX) ? HOLD_MAX : m_hold + 1;
      end
    end else begin
      if (rq[m_sel])   m_grant(m_sel);
      else if (rq[oth]) m_switch(oth);
    end
  endtask

  initial begin
    int flip_den;
    rst     = 1'b1;
    req_and = 1'b0;
    req_a0  = 1'b0;
    m_reset();
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      chk("sel",       32'(sel),       m_sel);
      chk("gnt_and",   32'(gnt_and),   (m_owner == 1) ? 1 : 0);
      chk("gnt_a0",    32'(gnt_a0),    (m_owner == 0) ? 1 : 0);
      chk("out_valid", 32'(out_valid), (m_blank == 0) ? 1 : 0);
      chk("busy",      32'(busy),      (m_blank == 0 && m_owner < 0) ? 0 : 1);
      if ((gnt_and || gnt_a0) && !out_valid) chk("gnt_while_blank", 32'(1), 0);
      if (gnt_and && gnt_a0)                 chk("two_grants", 32'(1), 0);
      // Alternate between busy request traffic and long steady holds.
      flip_den = (((cyc / 250) % 2) == 1) ? 40 : 6;
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, flip_den - 1) == 0) req_and = ~req_and;
      if ($urandom_range(0, flip_den - 1) == 0) req_a0  = ~req_a0;
      m_step(rst, req_a0, req_and);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
